// File: rtl/rgb_ycbcr_pkg.sv
// Shared constants and helpers for the BT.601 RGB -> YCbCr 4:2:2 converter.
package rgb_ycbcr_pkg;

  localparam int COEF_W    = 10;
  localparam int ACC_W     = 20;
  localparam int PIX_W     = 9;
  localparam int LATENCY   = 3;
  localparam int RND_SHIFT = 9;

  localparam int Y_MIN = 16;
  localparam int Y_MAX = 235;
  localparam int C_MIN = 16;
  localparam int C_MAX = 240;

  localparam logic [7:0] Y_BLANK = 8'h10;
  localparam logic [7:0] C_BLANK = 8'h80;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t kr;
    coef_t kg;
    coef_t kb;
  } coef3_t;

  // Coefficients are scaled by 512 against doubled (or pair-summed) RGB.
  localparam coef3_t Y_COEF  = '{kr: coef_t'(66),  kg: coef_t'(129), kb: coef_t'(25)};
  localparam coef3_t CB_COEF = '{kr: coef_t'(-38), kg: coef_t'(-74), kb: coef_t'(112)};
  localparam coef3_t CR_COEF = '{kr: coef_t'(112), kg: coef_t'(-94), kb: coef_t'(-18)};

  function automatic logic [7:0] clamp8(int v, int lo, int hi);
    if (v < lo) return 8'(lo);
    if (v > hi) return 8'(hi);
    return 8'(v);
  endfunction

endpackage

// File: rtl/rgb_to_ycbcr422_if.sv
// Pixel-stream bundle between the 4:2:2 pair stage (master) and the converter (slave).
interface rgb_to_ycbcr422_if;
  logic [8:0] r1_in, g1_in, b1_in;
  logic [8:0] r2_in, g2_in, b2_in;
  logic       pair_start_in;
  logic       hsync_in, vsync_in, de_in;
  logic [7:0] y_out, c_out;
  logic       c_is_cr_out;
  logic       hsync_out, vsync_out, de_out;

  modport master (
    output r1_in, g1_in, b1_in, r2_in, g2_in, b2_in, pair_start_in,
    output hsync_in, vsync_in, de_in,
    input  y_out, c_out, c_is_cr_out, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  r1_in, g1_in, b1_in, r2_in, g2_in, b2_in, pair_start_in,
    input  hsync_in, vsync_in, de_in,
    output y_out, c_out, c_is_cr_out, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/ycc_mac3.sv
// Three-term signed MAC: registered products, registered sum, then combinational
// round/shift/offset/clamp feeding the caller's output register.
module ycc_mac3
  import rgb_ycbcr_pkg::*;
#(
  parameter coef3_t COEF   = '0,
  parameter int     OFFSET = 0,
  parameter int     LO     = 0,
  parameter int     HI     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [7:0]       res
);

  localparam logic signed [ACC_W-1:0] KA    = ACC_W'(signed'(COEF.kr));
  localparam logic signed [ACC_W-1:0] KB    = ACC_W'(signed'(COEF.kg));
  localparam logic signed [ACC_W-1:0] KC    = ACC_W'(signed'(COEF.kb));
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1 << (RND_SHIFT - 1));

  logic signed [ACC_W-1:0] a_x, b_x, c_x;
  logic signed [ACC_W-1:0] pa_q, pb_q, pc_q;
  logic signed [ACC_W-1:0] sum_q, rnd;

  // Inputs are unsigned 0..511; zero-extend so the multiply stays signed.
  assign a_x = ACC_W'(a);
  assign b_x = ACC_W'(b);
  assign c_x = ACC_W'(c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q  <= '0;
      pb_q  <= '0;
      pc_q  <= '0;
      sum_q <= '0;
    end else begin
      pa_q  <= a_x * KA;
      pb_q  <= b_x * KB;
      pc_q  <= c_x * KC;
      sum_q <= pa_q + pb_q + pc_q;
    end
  end

  assign rnd = (sum_q + ROUND) >>> RND_SHIFT;
  assign res = clamp8(int'(rnd) + OFFSET, LO, HI);

endmodule

// File: rtl/rgb_to_ycbcr422.sv
// BT.601 studio-swing RGB -> YCbCr 4:2:2 converter, fixed 3-clock latency.
module rgb_to_ycbcr422
  import rgb_ycbcr_pkg::*;
#(
  parameter int Y_OFFSET = 16,
  parameter int C_OFFSET = 128,
  parameter int CLAMP_EN = 1
) (
  input logic              clk,
  input logic              rst,
  rgb_to_ycbcr422_if.slave bus
);

  localparam int YLo  = (CLAMP_EN != 0) ? Y_MIN : 0;
  localparam int YHi  = (CLAMP_EN != 0) ? Y_MAX : 255;
  localparam int CLo  = (CLAMP_EN != 0) ? C_MIN : 0;
  localparam int CHi  = (CLAMP_EN != 0) ? C_MAX : 255;
  localparam int Last = LATENCY - 2;
  localparam logic [7:0] CZero = 8'(C_OFFSET);

  logic [7:0] y_val, cb_val, cr_val;

  ycc_mac3 #(.COEF(Y_COEF), .OFFSET(Y_OFFSET), .LO(YLo), .HI(YHi)) u_mac_y (
    .clk (clk),
    .rst (rst),
    .a   (bus.r1_in),
    .b   (bus.g1_in),
    .c   (bus.b1_in),
    .res (y_val)
  );

  ycc_mac3 #(.COEF(CB_COEF), .OFFSET(C_OFFSET), .LO(CLo), .HI(CHi)) u_mac_cb (
    .clk (clk),
    .rst (rst),
    .a   (bus.r2_in),
    .b   (bus.g2_in),
    .c   (bus.b2_in),
    .res (cb_val)
  );

  ycc_mac3 #(.COEF(CR_COEF), .OFFSET(C_OFFSET), .LO(CLo), .HI(CHi)) u_mac_cr (
    .clk (clk),
    .rst (rst),
    .a   (bus.r2_in),
    .b   (bus.g2_in),
    .c   (bus.b2_in),
    .res (cr_val)
  );

  logic [LATENCY-2:0] de_q, hs_q, vs_q, start_q;
  logic [7:0]         y_q, c_q, cr_hold_q, c_sel;
  logic               c_is_cr_q, de_out_q, hs_out_q, vs_out_q;

  // A start always emits Cb, so a second back-to-back start overwrites the held Cr.
  always_comb begin
    c_sel = cr_hold_q;
    if (start_q[Last]) c_sel = cb_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q      <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
      start_q   <= '0;
      y_q       <= Y_BLANK;
      c_q       <= C_BLANK;
      c_is_cr_q <= 1'b0;
      de_out_q  <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      cr_hold_q <= CZero;
    end else begin
      de_q      <= {de_q[LATENCY-3:0], bus.de_in};
      hs_q      <= {hs_q[LATENCY-3:0], bus.hsync_in};
      vs_q      <= {vs_q[LATENCY-3:0], bus.vsync_in};
      start_q   <= {start_q[LATENCY-3:0], bus.pair_start_in};
      de_out_q  <= de_q[Last];
      hs_out_q  <= hs_q[Last];
      vs_out_q  <= vs_q[Last];
      y_q       <= de_q[Last] ? y_val : Y_BLANK;
      c_q       <= de_q[Last] ? c_sel : C_BLANK;
      c_is_cr_q <= ~start_q[Last];
      if (start_q[Last]) cr_hold_q <= cr_val;
    end
  end

  assign bus.y_out       = y_q;
  assign bus.c_out       = c_q;
  assign bus.c_is_cr_out = c_is_cr_q;
  assign bus.de_out      = de_out_q;
  assign bus.hsync_out   = hs_out_q;
  assign bus.vsync_out   = vs_out_q;

endmodule

// File: tb/tb_rgb_to_ycbcr422.sv
// Scoreboard bench: clamped and unclamped converters against an arithmetic BT.601 model.
module tb_rgb_to_ycbcr422;

  localparam int NcYOffset = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] r1 = '0, g1 = '0, b1 = '0, r2 = '0, g2 = '0, b2 = '0;
  logic       start = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;

  rgb_to_ycbcr422_if bus ();
  rgb_to_ycbcr422_if bus_nc ();

  assign bus.r1_in = r1;            assign bus_nc.r1_in = r1;
  assign bus.g1_in = g1;            assign bus_nc.g1_in = g1;
  assign bus.b1_in = b1;            assign bus_nc.b1_in = b1;
  assign bus.r2_in = r2;            assign bus_nc.r2_in = r2;
  assign bus.g2_in = g2;            assign bus_nc.g2_in = g2;
  assign bus.b2_in = b2;            assign bus_nc.b2_in = b2;
  assign bus.pair_start_in = start; assign bus_nc.pair_start_in = start;
  assign bus.hsync_in = hs;         assign bus_nc.hsync_in = hs;
  assign bus.vsync_in = vs;         assign bus_nc.vsync_in = vs;
  assign bus.de_in = de;            assign bus_nc.de_in = de;

  rgb_to_ycbcr422 #(.Y_OFFSET(16), .C_OFFSET(128), .CLAMP_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rgb_to_ycbcr422 #(.Y_OFFSET(NcYOffset), .C_OFFSET(128), .CLAMP_EN(0)) dut_nc (
    .clk (clk),
    .rst (rst),
    .bus (bus_nc)
  );

  typedef struct {
    int due;
    int y;
    int y_nc;
    int c;
    int is_cr;
    int hs;
    int vs;
    int de;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   held_cr = 128;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic int fdiv512(int n);
    int q;
    q = n / 512;
    if (n < 0 && q * 512 != n) q = q - 1;
    return q;
  endfunction

  function automatic int sat(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int luma(int r, int g, int b, int off, int lo, int hi);
    return sat(fdiv512(66 * r + 129 * g + 25 * b + 256) + off, lo, hi);
  endfunction

  function automatic int chroma_b(int r, int g, int b);
    return sat(fdiv512(-38 * r - 74 * g + 112 * b + 256) + 128, 16, 240);
  endfunction

  function automatic int chroma_r(int r, int g, int b);
    return sat(fdiv512(112 * r - 94 * g - 18 * b + 256) + 128, 16, 240);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_pix(input int ir1, input int ig1, input int ib1, input int ir2,
                           input int ig2, input int ib2, input int ist, input int ihs,
                           input int ivs, input int ide);
    exp_t e;
    int   cval;
    @(posedge clk);
    #1;
    r1 = 9'(ir1); g1 = 9'(ig1); b1 = 9'(ib1);
    r2 = 9'(ir2); g2 = 9'(ig2); b2 = 9'(ib2);
    start = (ist != 0); hs = (ihs != 0); vs = (ivs != 0); de = (ide != 0);
    e.due  = cyc + 3;
    e.hs   = ihs;
    e.vs   = ivs;
    e.de   = ide;
    e.y    = ide ? luma(ir1, ig1, ib1, 16, 16, 235) : 16;
    e.y_nc = ide ? luma(ir1, ig1, ib1, NcYOffset, 0, 255) : 16;
    if (ist != 0) begin
      cval    = chroma_b(ir2, ig2, ib2);
      held_cr = chroma_r(ir2, ig2, ib2);
      e.is_cr = 0;
    end else begin
      cval    = held_cr;
      e.is_cr = 1;
    end
    e.c = ide ? cval : 128;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    r1 = '0; g1 = '0; b1 = '0; r2 = '0; g2 = '0; b2 = '0;
    start = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    sb.delete();
    held_cr = 128;
    #1;
    chk("rst_y", bus.y_out, 16);
    chk("rst_c", bus.c_out, 128);
    chk("rst_is_cr", bus.c_is_cr_out, 0);
    chk("rst_hs", bus.hsync_out, 0);
    chk("rst_vs", bus.vsync_out, 0);
    chk("rst_de", bus.de_out, 0);
    chk("rst_nc_y", bus_nc.y_out, 16);
    chk("rst_nc_c", bus_nc.c_out, 128);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("y", bus.y_out, e.y);
        chk("c", bus.c_out, e.c);
        chk("c_is_cr", bus.c_is_cr_out, e.is_cr);
        chk("hsync", bus.hsync_out, e.hs);
        chk("vsync", bus.vsync_out, e.vs);
        chk("de", bus.de_out, e.de);
        chk("nc_y", bus_nc.y_out, e.y_nc);
        chk("nc_c", bus_nc.c_out, e.c);
        chk("nc_de", bus_nc.de_out, e.de);
      end
    end
  end

  initial begin
    int ph;
    int ist;
    int ide;
    apply_reset();
    // Non-start pixel before any start: held Cr is still the chroma zero level.
    drive_pix(100, 200, 300, 0, 0, 0, 0, 0, 0, 1);
    // Black, white, red, blue pairs.
    drive_pix(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive_pix(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive_pix(510, 510, 510, 510, 510, 510, 1, 0, 0, 1);
    drive_pix(510, 510, 510, 510, 510, 510, 0, 0, 0, 1);
    drive_pix(510, 0, 0, 510, 0, 0, 1, 0, 0, 1);
    drive_pix(510, 0, 0, 510, 0, 0, 0, 0, 0, 1);
    drive_pix(0, 0, 510, 0, 0, 510, 1, 0, 0, 1);
    drive_pix(0, 0, 510, 0, 0, 510, 0, 0, 0, 1);
    // Double start: red Cb then blue Cb, then blue Cr (red Cr discarded).
    drive_pix(510, 0, 0, 510, 0, 0, 1, 0, 0, 1);
    drive_pix(0, 0, 510, 0, 0, 510, 1, 0, 0, 1);
    drive_pix(0, 0, 510, 0, 0, 510, 0, 0, 0, 1);
    // Sync and de steps, blanked red pixels.
    drive_pix(510, 0, 0, 510, 0, 0, 1, 1, 0, 0);
    drive_pix(510, 0, 0, 510, 0, 0, 0, 1, 1, 0);
    drive_pix(510, 0, 0, 510, 0, 0, 1, 0, 1, 1);
    drive_pix(510, 0, 0, 510, 0, 0, 0, 0, 0, 1);
    // Out-of-range 511 drive: clamped vs saturated luma.
    drive_pix(511, 511, 511, 511, 511, 0, 1, 0, 0, 1);
    drive_pix(511, 511, 511, 511, 511, 0, 0, 0, 0, 1);
    // Mid-line reset with bright data in flight.
    drive_pix(510, 510, 510, 510, 0, 0, 1, 1, 1, 1);
    drive_pix(510, 510, 510, 510, 0, 0, 0, 1, 1, 1);
    apply_reset();
    drive_pix(300, 100, 50, 0, 0, 0, 0, 0, 0, 1);
    drive_pix(300, 100, 50, 400, 200, 100, 1, 0, 0, 1);
    drive_pix(300, 100, 50, 400, 200, 100, 0, 0, 0, 1);

    ph  = 0;
    ide = 1;
    for (int i = 0; i < 10000; i++) begin
      ist = (ph == 0 || $urandom_range(0, 31) == 0) ? 1 : 0;
      ph  = ist;
      if ($urandom_range(0, 63) == 0) ide = 1 - ide;
      drive_pix($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511),
                ist, ($urandom_range(0, 15) == 0) ? 1 : 0,
                ($urandom_range(0, 31) == 0) ? 1 : 0, ide);
    end

    repeat (6) @(posedge clk);
    #2;
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
